// File: rtl/rx_pp.sv
// rx_pp: router input port.
//   Accepts flits on a two-phase (toggle) req/ack channel, routes each packet on
//   its head flit through the shared routing table, and assembles packets into a
//   two-slot ping-pong buffer served by the switch allocator.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   ch_req/ch_flit  incoming channel: a toggle of ch_req marks a new flit
//   ch_ack          toggles once per accepted flit
//   sw_req/sw_chnl  level request and output channel to the switch allocator
//   sw_gnt          grant; the switch reads the buffer while high
//   buf_addr        flit index within the slot being served
//   buf_data        buffer read data (combinational)
//   table_addr      routing table lookup address
//   table_data      routing table result
//   slot_full       per-slot valid flags
//   proto_err       one-cycle pulse when a packet starts without a head flag
//   sink_count      packets consumed locally in sink mode
module rx_pp #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned PKT_BITS     = 3,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter bit          SINK_PACKETS = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ch_req,
  input  logic [SIZE-1:0]         ch_flit,
  output logic                    ch_ack,
  output logic                    sw_req,
  output logic [CHANNEL_BITS-1:0] sw_chnl,
  input  logic                    sw_gnt,
  input  logic [PKT_BITS-1:0]     buf_addr,
  output logic [SIZE-1:0]         buf_data,
  output logic [SIZE-2:0]         table_addr,
  input  logic [CHANNEL_BITS-1:0] table_data,
  output logic [1:0]              slot_full,
  output logic                    proto_err,
  output logic [15:0]             sink_count
);

  localparam int unsigned PKT_FLITS = 1 << PKT_BITS;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_LATCH,
    RX_DECODE,
    RX_RC,
    RX_STORE,
    RX_FULL_WAIT
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_SEND
  } tx_state_e;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic                                ch_req_old_q, ch_req_old_d;
  logic [SIZE-1:0]                     flit_q, flit_d;
  logic [PKT_BITS-1:0]                 cnt_q, cnt_d;
  logic                                wr_slot_q, wr_slot_d;
  logic                                rd_slot_q, rd_slot_d;
  logic [1:0]                          slot_full_q, slot_full_d;
  logic [1:0][CHANNEL_BITS-1:0]        channel_q, channel_d;
  logic                                ch_ack_q, ch_ack_d;
  logic                                sw_req_q, sw_req_d;
  logic [CHANNEL_BITS-1:0]             sw_chnl_q, sw_chnl_d;
  logic [SIZE-2:0]                     table_addr_q, table_addr_d;
  logic                                proto_err_q, proto_err_d;
  logic [15:0]                         sink_count_q, sink_count_d;

  logic [SIZE-1:0] mem_q [2][PKT_FLITS];
  logic            mem_we;

  logic req;
  logic is_head;
  logic pkt_start;
  logic pkt_last;

  assign req       = ch_req ^ ch_req_old_q;
  assign is_head   = flit_q[SIZE-1];
  assign pkt_start = (cnt_q == '0);
  assign pkt_last  = (cnt_q == '1);

  // The flit is captured on LATCH exit and ch_ack is registered on STORE exit,
  // giving a body ack two edges after the capture edge and a head ack three.
  always_comb begin
    rx_state_d   = rx_state_q;
    tx_state_d   = tx_state_q;
    ch_req_old_d = ch_req;
    flit_d       = flit_q;
    cnt_d        = cnt_q;
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    slot_full_d  = slot_full_q;
    channel_d    = channel_q;
    ch_ack_d     = ch_ack_q;
    sw_req_d     = sw_req_q;
    sw_chnl_d    = sw_chnl_q;
    table_addr_d = table_addr_q;
    proto_err_d  = 1'b0;
    sink_count_d = sink_count_q;
    mem_we       = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (req) rx_state_d = RX_LATCH;
      end
      RX_LATCH: begin
        flit_d     = ch_flit;
        rx_state_d = RX_DECODE;
      end
      RX_DECODE: begin
        // A head flag in the middle of a packet is ordinary payload.
        if (is_head && pkt_start) begin
          table_addr_d = flit_q[SIZE-2:0];
          rx_state_d   = RX_RC;
        end else begin
          rx_state_d = RX_STORE;
        end
      end
      RX_RC: begin
        channel_d[wr_slot_q] = table_data;
        rx_state_d           = RX_STORE;
      end
      RX_STORE: begin
        rx_state_d = RX_IDLE;
        if (pkt_start && !is_head) begin
          proto_err_d = 1'b1;
          ch_ack_d    = ~ch_ack_q;
        end else begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + PKT_BITS'(1);
          if (!pkt_last) begin
            ch_ack_d = ~ch_ack_q;
          end else if (SINK_PACKETS) begin
            sink_count_d = sink_count_q + 16'd1;
            ch_ack_d     = ~ch_ack_q;
          end else begin
            slot_full_d[wr_slot_q] = 1'b1;
            wr_slot_d              = ~wr_slot_q;
            // Backpressure only on the last flit: hold its ack until the
            // next slot to be written has been drained.
            if (!slot_full_q[~wr_slot_q]) ch_ack_d = ~ch_ack_q;
            else rx_state_d = RX_FULL_WAIT;
          end
        end
      end
      RX_FULL_WAIT: begin
        if (!slot_full_q[wr_slot_q]) begin
          ch_ack_d   = ~ch_ack_q;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // RX only ever sets the slot it writes and TX only clears the slot it
    // serves; those are never the same slot in one cycle.
    if (!SINK_PACKETS) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (slot_full_q[rd_slot_q]) begin
            sw_req_d   = 1'b1;
            sw_chnl_d  = channel_q[rd_slot_q];
            tx_state_d = TX_REQ;
          end
        end
        TX_REQ: begin
          if (sw_gnt) begin
            sw_req_d   = 1'b0;
            tx_state_d = TX_SEND;
          end
        end
        TX_SEND: begin
          if (!sw_gnt) begin
            slot_full_d[rd_slot_q] = 1'b0;
            rd_slot_d              = ~rd_slot_q;
            tx_state_d             = TX_IDLE;
          end
        end
        default: tx_state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      tx_state_q   <= TX_IDLE;
      ch_req_old_q <= 1'b0;
      flit_q       <= '0;
      cnt_q        <= '0;
      wr_slot_q    <= 1'b0;
      rd_slot_q    <= 1'b0;
      slot_full_q  <= '0;
      channel_q    <= '0;
      ch_ack_q     <= 1'b0;
      sw_req_q     <= 1'b0;
      sw_chnl_q    <= '0;
      table_addr_q <= '0;
      proto_err_q  <= 1'b0;
      sink_count_q <= '0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      ch_req_old_q <= ch_req_old_d;
      flit_q       <= flit_d;
      cnt_q        <= cnt_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      slot_full_q  <= slot_full_d;
      channel_q    <= channel_d;
      ch_ack_q     <= ch_ack_d;
      sw_req_q     <= sw_req_d;
      sw_chnl_q    <= sw_chnl_d;
      table_addr_q <= table_addr_d;
      proto_err_q  <= proto_err_d;
      sink_count_q <= sink_count_d;
    end
  end

  // Packet buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_slot_q][cnt_q] <= flit_q;
  end

  assign buf_data   = mem_q[rd_slot_q][buf_addr];
  assign ch_ack     = ch_ack_q;
  assign sw_req     = sw_req_q;
  assign sw_chnl    = sw_chnl_q;
  assign table_addr = table_addr_q;
  assign slot_full  = slot_full_q;
  assign proto_err  = proto_err_q;
  assign sink_count = sink_count_q;

endmodule

// File: tb/tb_rx_pp.sv
// Bench for rx_pp: routed, buffered instance plus a sink-mode instance.
module tb_rx_pp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       ch_req, ch_ack, sw_req, sw_gnt, proto_err;
  logic [7:0] ch_flit, sw_chnl, buf_data, table_data;
  logic [6:0] table_addr;
  logic [2:0] buf_addr;
  logic [1:0] slot_full;
  logic [15:0] sink_count;

  logic       s_ch_req, s_ch_ack, s_sw_req, s_sw_gnt, s_proto_err;
  logic [7:0] s_ch_flit, s_sw_chnl, s_buf_data, s_table_data;
  logic [6:0] s_table_addr;
  logic [2:0] s_buf_addr;
  logic [1:0] s_slot_full;
  logic [15:0] s_sink_count;

  rx_pp #(.SIZE(8), .PKT_BITS(3), .CHANNEL_BITS(8), .SINK_PACKETS(1'b0)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_flit(ch_flit), .ch_ack(ch_ack),
    .sw_req(sw_req), .sw_chnl(sw_chnl), .sw_gnt(sw_gnt), .buf_addr(buf_addr),
    .buf_data(buf_data), .table_addr(table_addr), .table_data(table_data),
    .slot_full(slot_full), .proto_err(proto_err), .sink_count(sink_count)
  );

  rx_pp #(.SIZE(8), .PKT_BITS(3), .CHANNEL_BITS(8), .SINK_PACKETS(1'b1)) dut_s (
    .clk(clk), .reset(reset), .ch_req(s_ch_req), .ch_flit(s_ch_flit), .ch_ack(s_ch_ack),
    .sw_req(s_sw_req), .sw_chnl(s_sw_chnl), .sw_gnt(s_sw_gnt), .buf_addr(s_buf_addr),
    .buf_data(s_buf_data), .table_addr(s_table_addr), .table_data(s_table_data),
    .slot_full(s_slot_full), .proto_err(s_proto_err), .sink_count(s_sink_count)
  );

  // Routing table: destination d maps to channel d-3.
  function automatic logic [7:0] route(input logic [6:0] a);
    return {1'b0, a} - 8'd3;
  endfunction

  assign table_data   = route(table_addr);
  assign s_table_data = route(s_table_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink-mode monitor: that instance must never request the switch or hold a slot.
  bit s_bad = 1'b0;
  always @(posedge clk) if (reset && (s_sw_req || s_slot_full != 2'b00)) s_bad = 1'b1;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]      ch;
    logic [7:0][7:0] f;
  } pkt_t;

  pkt_t       pend[$];   // completed packets awaiting the switch, oldest first
  pkt_t       m_pkt;
  logic [7:0] m_ch;
  int         m_cnt  = 0;
  int         m_sink = 0;
  logic       m_rd   = 1'b0;  // slot the switch will serve next (alternates)
  bit         sel    = 1'b0;  // 0: routed instance, 1: sink instance

  function automatic logic [1:0] exp_full();
    if (pend.size() == 0) return 2'b00;
    if (pend.size() == 1) return m_rd ? 2'b10 : 2'b01;
    return 2'b11;
  endfunction

  task automatic model_accept(input logic [7:0] f, output int el, output int ep);
    ep = 0;
    if (m_cnt == 0 && !f[7]) begin
      el = 4;
      ep = 1;
    end else begin
      el = (m_cnt == 0) ? 5 : 4;
      if (m_cnt == 0) m_ch = route(f[6:0]);
      m_pkt.f[m_cnt] = f;
      m_cnt++;
      if (m_cnt == 8) begin
        m_cnt = 0;
        if (sel) m_sink++;
        else begin
          m_pkt.ch = m_ch;
          pend.push_back(m_pkt);
        end
      end
    end
  endtask

  // ---------------- channel driver ----------------
  function automatic logic cur_ack();
    return sel ? s_ch_ack : ch_ack;
  endfunction

  function automatic logic cur_perr();
    return sel ? s_proto_err : proto_err;
  endfunction

  task automatic start_flit(input logic [7:0] f);
    if (sel) begin
      s_ch_flit = f;
      s_ch_req  = ~s_ch_req;
    end else begin
      ch_flit = f;
      ch_req  = ~ch_req;
    end
  endtask

  // Counts edges from the request toggle until ch_ack toggles (bounded).
  task automatic wait_ack(input logic old, input int bound, output int lat, output int perr_n);
    lat    = 0;
    perr_n = 0;
    while (lat < bound) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_perr()) perr_n++;
      if (cur_ack() != old) break;
    end
  endtask

  task automatic serve();
    pkt_t p;
    int   w;
    p = pend[0];
    w = 0;
    chk("slot_full_pending", slot_full, exp_full());
    while (!sw_req && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("sw_req_raised", sw_req, 1);
    chk("sw_chnl", sw_chnl, p.ch);
    sw_gnt = 1'b1;
    @(posedge clk);
    #1;
    chk("sw_req_dropped", sw_req, 0);
    for (int a = 0; a < 8; a++) begin
      buf_addr = 3'(a);
      #1;
      chk("buf_data", buf_data, p.f[a]);
    end
    sw_gnt = 1'b0;
    @(posedge clk);
    #1;
    void'(pend.pop_front());
    m_rd = ~m_rd;
    chk("slot_full_released", slot_full, exp_full());
    if (pend.size() > 0) begin
      @(posedge clk);
      #1;
      chk("sw_req_next_slot", sw_req, 1);
      chk("sw_chnl_next_slot", sw_chnl, pend[0].ch);
    end
  endtask

  task automatic send_flit(input logic [7:0] f);
    int   el, ep, lat, pn;
    logic old;
    bit   hold;
    hold = !sel && (m_cnt == 7) && (pend.size() == 1);
    model_accept(f, el, ep);
    old = cur_ack();
    start_flit(f);
    if (hold) begin
      wait_ack(old, 12, lat, pn);
      chk("ack_withheld", cur_ack(), old);
      chk("slot_full_both", slot_full, 2'b11);
      serve();
      chk("ack_released", ch_ack, !old);
    end else begin
      wait_ack(old, 50, lat, pn);
      chk("ack_latency", lat, el);
      chk("proto_err_pulse", pn, ep);
    end
  endtask

  task automatic send_pkt(input logic [6:0] dest);
    send_flit({1'b1, dest});
    for (int k = 1; k < 8; k++) send_flit(8'($urandom));
  endtask

  task automatic chk_reset();
    chk("rst_ch_ack", ch_ack, 0);
    chk("rst_sw_req", sw_req, 0);
    chk("rst_sw_chnl", sw_chnl, 0);
    chk("rst_table_addr", table_addr, 0);
    chk("rst_slot_full", slot_full, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_sink_count", s_sink_count, 0);
  endtask

  typedef struct {
    logic [7:0] flit;
    int         lat;
    int         perr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pkt_t tp;
    int   lat, pn;
    logic old;

    reset = 1'b0;
    ch_req = 1'b0; ch_flit = '0; sw_gnt = 1'b0; buf_addr = '0;
    s_ch_req = 1'b0; s_ch_flit = '0; s_sw_gnt = 1'b0; s_buf_addr = '0;

    // Protocol-error flit then a single packet routed to 0x05 -> channel 0x02.
    tbl[0] = '{8'h13, 4, 1};
    tbl[1] = '{8'h85, 5, 0};
    for (int i = 0; i < 7; i++) tbl[i+2] = '{8'(8'h11 + i), 4, 0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      old = ch_ack;
      start_flit(tbl[i].flit);
      wait_ack(old, 50, lat, pn);
      chk("vec_ack_latency", lat, tbl[i].lat);
      chk("vec_proto_err", pn, tbl[i].perr);
    end
    chk("t2_slot_full", slot_full, 2'b01);
    chk("t2_table_addr", table_addr, 7'h05);
    chk("t2_sw_req_early", sw_req, 0);
    @(posedge clk);
    #1;
    chk("t2_sw_req", sw_req, 1);
    chk("t2_sw_chnl", sw_chnl, 8'h02);

    tp.ch = 8'h02;
    tp.f[0] = 8'h85;
    for (int i = 0; i < 7; i++) tp.f[i+1] = 8'(8'h11 + i);
    pend.push_back(tp);

    // Reset in the middle of a packet (three flits in).
    send_flit(8'h9A);
    send_flit(8'h21);
    send_flit(8'h22);
    reset  = 1'b0;
    ch_req = 1'b0;
    #2;
    chk_reset();
    m_cnt = 0;
    pend.delete();
    m_rd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // First packet after reset lands in slot 0 starting at index 0.
    send_pkt(7'h45);
    serve();

    // Ping-pong: A waits, B's last ack held until A is released.
    send_pkt(7'h10);
    send_pkt(7'h2C);
    serve();

    // Randomized traffic with occasional headless packet starts.
    for (int p = 0; p < 12; p++) begin
      if ($urandom_range(0, 3) == 0) send_flit(8'($urandom_range(0, 127)));
      send_pkt(7'($urandom_range(3, 127)));
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) serve();
    end
    while (pend.size() > 0) serve();

    // Sink-mode instance: three packets back to back.
    sel   = 1'b1;
    m_cnt = 0;
    for (int p = 0; p < 3; p++) send_pkt(7'($urandom_range(3, 127)));
    repeat (2) @(posedge clk);
    #1;
    chk("sink_count", s_sink_count, 16'(m_sink));
    chk("sink_count_three", s_sink_count, 16'd3);
    chk("sink_no_switch_activity", s_bad, 0);
    chk("sink_slot_full", s_slot_full, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
